// File: rtl/pc_fetch_if.sv
// Fetch-side bundle for the PC unit: control inputs, redirect/trap inputs,
// and the imem request with its status outputs.
//
// Handshake: the PC unit asserts fetch_valid_o with the address on pc_o; a
// request is accepted on a rising clock edge where fetch_valid_o and
// fetch_ready_i are both 1. While fetch_valid_o is 1 and the request has not
// been accepted, pc_o holds its value. fetch_ready_i may change at any time
// and never depends on fetch_valid_o through a combinational path here.
interface pc_fetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            start_i;
   logic            halt_i;
   logic            stall_i;
   logic            redirect_valid_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            trap_i;
   logic            fetch_ready_i;
   logic            fetch_valid_o;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] pc_next_o;
   logic            redirect_pending_o;
   logic [1:0]      state_o;

   // PC unit side: drives the fetch request
   modport master (
      input  start_i, halt_i, stall_i, redirect_valid_i, redirect_pc_i, trap_i,
             fetch_ready_i,
      output fetch_valid_o, pc_o, pc_next_o, redirect_pending_o, state_o
   );

   // Pipeline/imem side: consumes the fetch request
   modport slave (
      output start_i, halt_i, stall_i, redirect_valid_i, redirect_pc_i, trap_i,
             fetch_ready_i,
      input  fetch_valid_o, pc_o, pc_next_o, redirect_pending_o, state_o
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter unit: holds the fetch PC, issues valid/ready fetch requests,
// selects the next PC (trap, redirect, stall, sequential), buffers redirects
// that arrive while a request is waiting, and sequences run/halt with an FSM.
module pc_fetch_ctrl #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     INC       = 4,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0080)
) (
   input  logic       clk_i,
   input  logic       rst_i,
   pc_fetch_if.master bus
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_HALT = 2'b10;

   // Targets are aligned to the increment; INC is a power of two.
   localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_W - XLEN'(1));

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] target_q;
   logic            pend_redir_q;
   logic            pend_trap_q;
   logic            halt_req_q, halt_req_d;
   logic            fetch_valid;
   logic            accept;

   assign fetch_valid = (state_q == ST_RUN);
   assign accept      = fetch_valid & bus.fetch_ready_i;
   assign pc_next     = pc_q + INC_W;

   assign bus.fetch_valid_o      = fetch_valid;
   assign bus.pc_o               = pc_q;
   assign bus.pc_next_o          = pc_next;
   assign bus.redirect_pending_o = pend_redir_q | pend_trap_q;
   assign bus.state_o            = state_q;

   // Next PC: only moves on an accepted request, so the address stays stable otherwise
   always_comb begin
      pc_d = pc_q;
      if (accept) begin
         if (bus.trap_i || pend_trap_q) begin
            pc_d = TRAP_VEC & ALIGN_MASK;
         end else if (pend_redir_q) begin
            pc_d = target_q;
         end else if (bus.redirect_valid_i) begin
            pc_d = bus.redirect_pc_i & ALIGN_MASK;
         end else if (bus.stall_i) begin
            pc_d = pc_q;
         end else begin
            pc_d = pc_next;
         end
      end
   end

   // Run/halt FSM next state and halt request tracking
   always_comb begin
      state_d    = state_q;
      halt_req_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (bus.start_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            halt_req_d = halt_req_q | bus.halt_i;
            if (accept) begin
               halt_req_d = 1'b0;
               if (halt_req_q || bus.halt_i) begin
                  state_d = ST_HALT;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, PC and halt request registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_VEC;
         halt_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         halt_req_q <= halt_req_d;
      end
   end

   // Redirect/trap buffer: captures events while a request waits, cleared on accept
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pend_redir_q <= 1'b0;
         pend_trap_q  <= 1'b0;
         target_q     <= '0;
      end else if (accept) begin
         pend_redir_q <= 1'b0;
         pend_trap_q  <= 1'b0;
      end else if (fetch_valid) begin
         if (bus.trap_i) begin
            pend_trap_q <= 1'b1;
         end
         if (bus.redirect_valid_i && !pend_trap_q) begin
            pend_redir_q <= 1'b1;
            target_q     <= bus.redirect_pc_i & ALIGN_MASK;
         end
      end
   end

endmodule
